hazard_flush_ctrl: RTL and testbench
====================================

Name: hazard_flush_ctrl

Overview:
- Pipeline hazard controller for each core. It sits between IF/ID/EX stage registers and the ID-stage decoder.
- Produces the two flush inputs the decoder consumes: flush1 kills the IF/ID register contents, flush2 zeroes the ID-stage control word.
- Also produces PC and IF/ID write enables.
- Handles three hazard classes: load-use stalls, multi-cycle MUL stalls, and taken-branch or jump flushes. Keeps saturating stall and flush counters for performance readout.

Parameters:
- MUL_LAT, 4, total cycles a MUL (op 0, funct 0x18) occupies ID. Legal range 2..16.
- CNT_W, 16, width of the performance counters.

Ports:
- clk_i  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_op_i  in  6  opcode of the instruction in ID
- id_funct_i  in  6  funct field of the instruction in ID
- id_rs_i  in  5  rs field of the instruction in ID
- id_rt_i  in  5  rt field of the instruction in ID
- ex_memread_i  in  1  instruction in EX is a load
- ex_rt_i  in  5  destination rt of the instruction in EX
- ex_branch_taken_i  in  1  branch in EX resolved taken this cycle
- cnt_clr_i  in  1  synchronous clear of both counters
- flush1_o  out  1  flush IF/ID register / decoder flush1
- flush2_o  out  1  zero ID control word / decoder flush2
- pc_write_o  out  1  PC update enable
- ifid_write_o  out  1  IF/ID register write enable
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0, saturating
- flush_cnt_o  out  CNT_W  cycles with flush1_o=1, saturating

Behaviour:
- Reset is asynchronous and active-low on rst_n. The block has one clock, clk_i.
- Reset values: state IDLE, mul counter 0, stall_cnt_o=0, flush_cnt_o=0.
- Outputs are combinational from state and inputs, so in reset they read flush1_o=0, flush2_o=0, pc_write_o=1, ifid_write_o=1.
- Default outputs, when no case below applies: flush1=0, flush2=0, pc_write=1, ifid_write=1.
- uses_rs = NOT (op==0x02 jump, op==0x0F lui, or op==0 with funct==0 shift).
- uses_rt = op is one of 0x00, 0x04, 0x05, 0x2B.
- load_use = ex_memread_i AND ex_rt_i!=0 AND ((uses_rs AND ex_rt_i==id_rs_i) OR (uses_rt AND ex_rt_i==id_rt_i)).
- is_mul = op==0 AND funct==0x18.
- FSM has two states: IDLE and MUL_WAIT. mcnt is 4 bits.
- IDLE, evaluated in priority order:
  1. ex_branch_taken_i: flush1=1, flush2=1, writes enabled. Stay IDLE.
  2. load_use: pc_write=0, ifid_write=0, flush2=1. Stay IDLE. EX then advances, so the stall is exactly one bubble.
  3. is_mul: pc_write=0, ifid_write=0, flush2=1. Load mcnt=MUL_LAT-2, go to MUL_WAIT.
  4. op==0x02 jump: flush1=1 only.
- MUL_WAIT:
  - ex_branch_taken_i: branch outputs as in IDLE, mcnt<=0, go to IDLE. The stalled MUL is wrong-path and is discarded.
  - Else if mcnt!=0: stall outputs as in case 3, mcnt decrements.
  - Else mcnt==0: release cycle with default outputs, go to IDLE. The MUL advances and is not re-detected.
- Stall count: a MUL stalls exactly MUL_LAT-1 cycles, then releases on the MUL_LAT-th cycle.
- MUL_LAT=2: MUL_WAIT is entered with mcnt=0, giving exactly one stall cycle.
- Counters:
  - On each clock edge, stall_cnt increments if pc_write_o==0, and flush_cnt increments if flush1_o==1.
  - Both saturate at all-ones and do not wrap.
  - cnt_clr_i=1 zeroes both counters; clear takes priority over increment in the same cycle.
- Reset asserted mid-MUL_WAIT returns the block to IDLE immediately, with counters cleared.
- Simultaneous events: branch beats load-use beats MUL beats jump. A load-use on a MUL source produces a load-use stall first; MUL detection happens in the following cycle.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, release -> pc_write_o=1, ifid_write_o=1, flush1_o=0, flush2_o=0, both counters 0.
- Load-use: ex_memread_i=1, ex_rt_i=5, ID holds add with rs=5 -> exactly 1 cycle of pc_write_o=0 and flush2_o=1; stall_cnt_o=1. With ex_rt_i=0 or ID=lui -> no stall.
- MUL, MUL_LAT=4: ID holds op 0 funct 0x18 -> pc_write_o=0 for 3 cycles, then 1 release cycle, then IDLE; stall_cnt_o=3.
- Branch abort: MUL stall in progress, ex_branch_taken_i=1 in its 2nd stall cycle -> that cycle flush1_o=1, flush2_o=1, pc_write_o=1; the next cycle is IDLE with no stall.
- Priority and jump: branch taken together with load_use -> flush only, no stall. ID op 0x02 with no other hazard -> flush1_o=1, flush2_o=0, flush_cnt_o increments.
- Saturation and clear: preload stall_cnt_o to 0xFFFF, then stall again -> stays 0xFFFF. cnt_clr_i=1 during a stall -> 0 on the next cycle.

Source files
------------

// File: rtl/hazard_flush_ctrl.sv
// Per-core pipeline hazard controller: load-use and MUL stalls, branch/jump flushes,
// and saturating stall/flush performance counters.
module hazard_flush_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [5:0]       id_op_i,
    input  logic [5:0]       id_funct_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             ex_branch_taken_i,
    input  logic             cnt_clr_i,
    output logic             flush1_o,
    output logic             flush2_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic {
        IDLE,
        MUL_WAIT
    } state_t;

    localparam logic [3:0] MCNT_INIT = 4'(MUL_LAT - 2);

    state_t     state, state_nxt;
    logic [3:0] mcnt, mcnt_nxt;
    logic       uses_rs, uses_rt, load_use, is_mul, is_jump;

    always_comb begin
        is_jump  = (id_op_i == 6'h02);
        is_mul   = (id_op_i == 6'h00) && (id_funct_i == 6'h18);
        uses_rs  = !(is_jump || (id_op_i == 6'h0F) ||
                     ((id_op_i == 6'h00) && (id_funct_i == 6'h00)));
        uses_rt  = (id_op_i == 6'h00) || (id_op_i == 6'h04) ||
                   (id_op_i == 6'h05) || (id_op_i == 6'h2B);
        load_use = ex_memread_i && (ex_rt_i != 5'd0) &&
                   ((uses_rs && (ex_rt_i == id_rs_i)) ||
                    (uses_rt && (ex_rt_i == id_rt_i)));
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mcnt  <= '0;
        end else begin
            state <= state_nxt;
            mcnt  <= mcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mcnt_nxt  = mcnt;
        case (state)
            IDLE: begin
                if (!ex_branch_taken_i && !load_use && is_mul) begin
                    state_nxt = MUL_WAIT;
                    mcnt_nxt  = MCNT_INIT;
                end
            end
            MUL_WAIT: begin
                if (ex_branch_taken_i) begin
                    state_nxt = IDLE;
                    mcnt_nxt  = '0;
                end else if (mcnt != 4'd0) begin
                    mcnt_nxt = mcnt - 4'd1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                mcnt_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        flush1_o     = 1'b0;
        flush2_o     = 1'b0;
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        case (state)
            IDLE: begin
                if (ex_branch_taken_i) begin
                    flush1_o = 1'b1;
                    flush2_o = 1'b1;
                end else if (load_use || is_mul) begin
                    pc_write_o   = 1'b0;
                    ifid_write_o = 1'b0;
                    flush2_o     = 1'b1;
                end else if (is_jump) begin
                    flush1_o = 1'b1;
                end
            end
            MUL_WAIT: begin
                if (ex_branch_taken_i) begin
                    flush1_o = 1'b1;
                    flush2_o = 1'b1;
                end else if (mcnt != 4'd0) begin
                    pc_write_o   = 1'b0;
                    ifid_write_o = 1'b0;
                    flush2_o     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Clear wins over increment; counters hold at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (!pc_write_o && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (flush1_o && (flush_cnt_o != '1))
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Scoreboard bench for hazard_flush_ctrl: two instances (MUL_LAT=4/CNT_W=16 and
// MUL_LAT=2/CNT_W=4) share stimulus and are checked against a behavioural model.
module tb_hazard_flush_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] id_op, id_funct;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       ex_memread, ex_branch_taken, cnt_clr;

    logic        f1_a, f2_a, pcw_a, ifw_a;
    logic [15:0] sc_a, fc_a;
    logic        f1_b, f2_b, pcw_b, ifw_b;
    logic [3:0]  sc_b, fc_b;

    always #5 clk = ~clk;

    hazard_flush_ctrl #(.MUL_LAT(4), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_n(rst_n), .id_op_i(id_op), .id_funct_i(id_funct),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
        .ex_branch_taken_i(ex_branch_taken), .cnt_clr_i(cnt_clr),
        .flush1_o(f1_a), .flush2_o(f2_a), .pc_write_o(pcw_a), .ifid_write_o(ifw_a),
        .stall_cnt_o(sc_a), .flush_cnt_o(fc_a));

    hazard_flush_ctrl #(.MUL_LAT(2), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_n(rst_n), .id_op_i(id_op), .id_funct_i(id_funct),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
        .ex_branch_taken_i(ex_branch_taken), .cnt_clr_i(cnt_clr),
        .flush1_o(f1_b), .flush2_o(f2_b), .pc_write_o(pcw_b), .ifid_write_o(ifw_b),
        .stall_cnt_o(sc_b), .flush_cnt_o(fc_b));

    typedef struct {
        bit f1, f2, pcw, ifw;
        int sc, fc;
    } exp_t;

    exp_t q[2][$];
    int   checks = 0;
    int   errors = 0;

    // Model state: whether a MUL is being held, and how many more stall cycles it needs.
    bit mul_busy[2];
    int mul_left[2];
    int cnt_s[2];
    int cnt_f[2];
    int lat[2]  = '{4, 2};
    int cmax[2] = '{65535, 15};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit reads_rs(input logic [5:0] op, input logic [5:0] fn);
        return !(op == 6'h02 || op == 6'h0F || (op == 6'h00 && fn == 6'h00));
    endfunction

    function automatic bit reads_rt(input logic [5:0] op);
        return op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2B;
    endfunction

    task automatic cycle(input bit rst, input bit br, input bit mr, input bit clr,
                         input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ert);
        bit lu, mul;
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = !rst; ex_branch_taken = br; ex_memread = mr; cnt_clr = clr;
        id_op = op; id_funct = fn; id_rs = rs; id_rt = rt; ex_rt = ert;
        lu  = mr && ert != 0 && ((reads_rs(op, fn) && ert == rs) || (reads_rt(op) && ert == rt));
        mul = op == 6'h00 && fn == 6'h18;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mul_busy[k] = 0; cnt_s[k] = 0; cnt_f[k] = 0;
            end
            e = '{f1: 0, f2: 0, pcw: 1, ifw: 1, sc: cnt_s[k], fc: cnt_f[k]};
            if (br) begin
                e.f1 = 1; e.f2 = 1;
                mul_busy[k] = 0;
            end else if (mul_busy[k]) begin
                if (mul_left[k] > 0) begin
                    e.pcw = 0; e.ifw = 0; e.f2 = 1;
                    mul_left[k]--;
                end else begin
                    mul_busy[k] = 0;
                end
            end else if (lu || mul) begin
                e.pcw = 0; e.ifw = 0; e.f2 = 1;
                if (!lu) begin
                    mul_busy[k] = 1; mul_left[k] = lat[k] - 2;
                end
            end else if (op == 6'h02) begin
                e.f1 = 1;
            end
            q[k].push_back(e);
            if (rst) mul_busy[k] = 0;
            else if (clr) begin
                cnt_s[k] = 0; cnt_f[k] = 0;
            end else begin
                if (!e.pcw && cnt_s[k] < cmax[k]) cnt_s[k]++;
                if (e.f1 && cnt_f[k] < cmax[k]) cnt_f[k]++;
            end
        end
    endtask

    task automatic idle_cycle();
        cycle(0, 0, 0, 0, 6'h00, 6'h20, 5'd1, 5'd2, 5'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q[0].size() > 0) begin
                e = q[0].pop_front();
                check("a_flush1", int'(f1_a), int'(e.f1));
                check("a_flush2", int'(f2_a), int'(e.f2));
                check("a_pc_write", int'(pcw_a), int'(e.pcw));
                check("a_ifid_write", int'(ifw_a), int'(e.ifw));
                check("a_stall_cnt", int'(sc_a), e.sc);
                check("a_flush_cnt", int'(fc_a), e.fc);
            end
            if (q[1].size() > 0) begin
                e = q[1].pop_front();
                check("b_flush1", int'(f1_b), int'(e.f1));
                check("b_flush2", int'(f2_b), int'(e.f2));
                check("b_pc_write", int'(pcw_b), int'(e.pcw));
                check("b_ifid_write", int'(ifw_b), int'(e.ifw));
                check("b_stall_cnt", int'(sc_b), e.sc);
                check("b_flush_cnt", int'(fc_b), e.fc);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin : stimulus
        logic [5:0] ops[8]   = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h0F, 6'h23, 6'h2B, 6'h08};
        logic [5:0] fns[3]   = '{6'h00, 6'h18, 6'h20};
        rst_n = 1'b0; ex_branch_taken = 0; ex_memread = 0; cnt_clr = 0;
        id_op = '0; id_funct = 6'h20; id_rs = '0; id_rt = '0; ex_rt = '0;

        repeat (3) cycle(1, 0, 0, 0, 6'h00, 6'h20, 5'd1, 5'd2, 5'd0);
        idle_cycle();

        // load-use on rs, then the load has advanced
        cycle(0, 0, 1, 0, 6'h00, 6'h20, 5'd5, 5'd6, 5'd5);
        idle_cycle();
        cycle(0, 0, 1, 0, 6'h00, 6'h20, 5'd0, 5'd6, 5'd0);
        cycle(0, 0, 1, 0, 6'h0F, 6'h00, 5'd5, 5'd6, 5'd5);

        // MUL held in ID until released
        repeat (4) cycle(0, 0, 0, 0, 6'h00, 6'h18, 5'd3, 5'd4, 5'd0);
        idle_cycle();

        // MUL aborted by a taken branch in its second stall cycle
        cycle(0, 0, 0, 0, 6'h00, 6'h18, 5'd3, 5'd4, 5'd0);
        cycle(0, 1, 0, 0, 6'h00, 6'h18, 5'd3, 5'd4, 5'd0);
        idle_cycle();

        // branch beats load-use, then plain jump
        cycle(0, 1, 1, 0, 6'h00, 6'h20, 5'd7, 5'd8, 5'd7);
        cycle(0, 0, 0, 0, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0);
        idle_cycle();

        // load-use on a MUL source, MUL detected afterwards
        cycle(0, 0, 1, 0, 6'h00, 6'h18, 5'd9, 5'd4, 5'd9);
        repeat (4) cycle(0, 0, 0, 0, 6'h00, 6'h18, 5'd9, 5'd4, 5'd0);

        // saturation of the narrow counters, then clear during a stall
        repeat (20) cycle(0, 0, 1, 0, 6'h2B, 6'h00, 5'd1, 5'd6, 5'd6);
        repeat (20) cycle(0, 0, 0, 0, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0);
        cycle(0, 0, 1, 1, 6'h2B, 6'h00, 5'd1, 5'd6, 5'd6);
        idle_cycle();

        // reset in the middle of a MUL stall
        repeat (2) cycle(0, 0, 0, 0, 6'h00, 6'h18, 5'd3, 5'd4, 5'd0);
        cycle(1, 0, 0, 0, 6'h00, 6'h20, 5'd1, 5'd2, 5'd0);
        idle_cycle();

        for (int n = 0; n < 2000; n++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
                  1'($urandom), ($urandom_range(0, 31) == 0),
                  ops[$urandom_range(0, 7)], fns[$urandom_range(0, 2)],
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        check("queue_a_drained", q[0].size(), 0);
        check("queue_b_drained", q[1].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
